// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single shared memory with a fixed read latency.
// One transaction in flight: IDLE (arbitrate) -> ACCESS (MEM_LAT cycles) -> DONE.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       sel;       // port owning the current transaction
    logic       last;      // port granted most recently
    logic       pick1;

    // Port 1 wins when alone, or on contention when port 0 was granted last.
    always_comb begin
        pick1 = req1 & (~req0 | ~last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= 1'b0;
            last    <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
            mem_we  <= 1'b0;
            mem_adr <= '0;
            mem_wd  <= '0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        sel     <= pick1;
                        last    <= pick1;
                        gnt0    <= ~pick1;
                        gnt1    <= pick1;
                        mem_we  <= pick1 ? we1  : we0;
                        mem_adr <= pick1 ? adr1 : adr0;
                        mem_wd  <= pick1 ? wd1  : wd0;
                        cnt     <= 4'(MEM_LAT - 1);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (sel) begin
                            rd1   <= mem_rd;
                            done1 <= 1'b1;
                        end else begin
                            rd0   <= mem_rd;
                            done0 <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3 share clock and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    // instance a: MEM_LAT = 1
    logic        a_req0, a_we0, a_req1, a_we1;
    logic [31:0] a_adr0, a_wd0, a_adr1, a_wd1, a_rd0, a_rd1, a_mem_adr, a_mem_wd, a_mem_rd;
    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_mem_we;

    // instance b: MEM_LAT = 3
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [31:0] b_adr0, b_wd0, b_adr1, b_wd1, b_rd0, b_rd1, b_mem_adr, b_mem_wd, b_mem_rd;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_mem_we;

    mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dut_a (
        .clk(clk), .reset(reset),
        .req0(a_req0), .we0(a_we0), .adr0(a_adr0), .wd0(a_wd0),
        .req1(a_req1), .we1(a_we1), .adr1(a_adr1), .wd1(a_wd1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
        .rd0(a_rd0), .rd1(a_rd1),
        .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd)
    );

    mem_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .we0(b_we0), .adr0(b_adr0), .wd0(b_wd0),
        .req1(b_req1), .we1(b_we1), .adr1(b_adr1), .wd1(b_wd1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rd0(b_rd0), .rd1(b_rd1),
        .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b_idle_outputs(input string tag);
        chk({tag, "_gnt0"}, 32'(b_gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(b_gnt1), 32'd0);
        chk({tag, "_done0"}, 32'(b_done0), 32'd0);
        chk({tag, "_done1"}, 32'(b_done1), 32'd0);
        chk({tag, "_mem_we"}, 32'(b_mem_we), 32'd0);
        chk({tag, "_mem_adr"}, b_mem_adr, 32'd0);
        chk({tag, "_mem_wd"}, b_mem_wd, 32'd0);
        chk({tag, "_rd0"}, b_rd0, 32'd0);
        chk({tag, "_rd1"}, b_rd1, 32'd0);
    endtask

    initial begin
        {a_req0, a_we0, a_req1, a_we1} = '0;
        {a_adr0, a_wd0, a_adr1, a_wd1, a_mem_rd} = '0;
        {b_req0, b_we0, b_req1, b_we1} = '0;
        {b_adr0, b_wd0, b_adr1, b_wd1, b_mem_rd} = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_b_idle_outputs("rst");
        chk("rst_a_gnt0", 32'(a_gnt0), 32'd0);
        chk("rst_a_mem_we", 32'(a_mem_we), 32'd0);

        // MEM_LAT=1 write: port 0, adr 100, wd 7
        @(negedge clk);
        reset = 1'b1;
        a_req0 = 1'b1; a_we0 = 1'b1; a_adr0 = 32'd100; a_wd0 = 32'd7;
        step();
        chk("a_wr_gnt0", 32'(a_gnt0), 32'd1);
        chk("a_wr_gnt1", 32'(a_gnt1), 32'd0);
        chk("a_wr_mem_we", 32'(a_mem_we), 32'd1);
        chk("a_wr_mem_adr", a_mem_adr, 32'd100);
        chk("a_wr_mem_wd", a_mem_wd, 32'd7);
        a_req0 = 1'b0; a_adr0 = 32'd0; a_wd0 = 32'd0;
        step();
        chk("a_wr_done0", 32'(a_done0), 32'd1);
        chk("a_wr_we_off", 32'(a_mem_we), 32'd0);
        chk("a_wr_gnt0_off", 32'(a_gnt0), 32'd0);
        step();
        chk("a_wr_done0_off", 32'(a_done0), 32'd0);
        chk("a_wr_adr_hold", a_mem_adr, 32'd100);

        // MEM_LAT=3 read: port 1, adr 96, memory returns 0x1234
        b_req1 = 1'b1; b_we1 = 1'b0; b_adr1 = 32'd96;
        step();
        chk("b_rd_gnt1", 32'(b_gnt1), 32'd1);
        chk("b_rd_gnt0", 32'(b_gnt0), 32'd0);
        chk("b_rd_mem_we", 32'(b_mem_we), 32'd0);
        chk("b_rd_mem_adr", b_mem_adr, 32'd96);
        b_req1 = 1'b0; b_adr1 = 32'd0;
        b_mem_rd = 32'h1234;
        step();
        chk("b_rd_c1_gnt1", 32'(b_gnt1), 32'd0);
        chk("b_rd_c1_done1", 32'(b_done1), 32'd0);
        chk("b_rd_c1_adr", b_mem_adr, 32'd96);
        step();
        chk("b_rd_c2_done1", 32'(b_done1), 32'd0);
        chk("b_rd_c2_we", 32'(b_mem_we), 32'd0);
        step();
        chk("b_rd_done1", 32'(b_done1), 32'd1);
        chk("b_rd_done0", 32'(b_done0), 32'd0);
        chk("b_rd_rd1", b_rd1, 32'h1234);
        b_mem_rd = 32'hdead;
        step();
        chk("b_rd_done1_off", 32'(b_done1), 32'd0);
        chk("b_rd_rd1_hold", b_rd1, 32'h1234);

        // port 0 write, with a one-cycle req1 pulse during ACCESS that must be ignored
        b_req0 = 1'b1; b_we0 = 1'b1; b_adr0 = 32'd100; b_wd0 = 32'd7;
        step();
        chk("b_wr_gnt0", 32'(b_gnt0), 32'd1);
        chk("b_wr_mem_we", 32'(b_mem_we), 32'd1);
        chk("b_wr_mem_adr", b_mem_adr, 32'd100);
        chk("b_wr_mem_wd", b_mem_wd, 32'd7);
        b_req0 = 1'b0; b_we0 = 1'b0; b_adr0 = 32'd0; b_wd0 = 32'd0;
        b_req1 = 1'b1; b_adr1 = 32'd44;
        step();
        chk("b_wr_we_once", 32'(b_mem_we), 32'd0);
        chk("b_pulse_gnt1", 32'(b_gnt1), 32'd0);
        chk("b_wr_wd_hold", b_mem_wd, 32'd7);
        b_req1 = 1'b0; b_adr1 = 32'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b_pulse_no_gnt1", 32'(b_gnt1), 32'd0);
            chk("b_pulse_no_done1", 32'(b_done1), 32'd0);
            chk("b_wr_done0", 32'(b_done0), (i == 1) ? 32'd1 : 32'd0);
        end
        chk("b_idle_adr_hold", b_mem_adr, 32'd100);
        chk("b_idle_we", 32'(b_mem_we), 32'd0);

        // both requesting: last grant was port 0, so port 1 goes first, then alternate
        b_req0 = 1'b1; b_adr0 = 32'd8;
        b_req1 = 1'b1; b_adr1 = 32'd12;
        b_mem_rd = 32'h0;
        for (int i = 0; i < 20; i++) begin
            logic exp_p1;
            step();
            exp_p1 = ((i / 5) % 2) == 0;
            chk("rr_gnt1", 32'(b_gnt1), 32'((i % 5 == 0) && exp_p1));
            chk("rr_gnt0", 32'(b_gnt0), 32'((i % 5 == 0) && !exp_p1));
            chk("rr_done1", 32'(b_done1), 32'((i % 5 == 3) && exp_p1));
            chk("rr_done0", 32'(b_done0), 32'((i % 5 == 3) && !exp_p1));
            if (i % 5 == 0)
                chk("rr_mem_adr", b_mem_adr, exp_p1 ? 32'd12 : 32'd8);
        end

        // reset mid-ACCESS of a port-1 read, both requests held
        b_adr0 = 32'd200; b_mem_rd = 32'h77;
        step();
        chk("ra_gnt1", 32'(b_gnt1), 32'd1);
        chk("ra_mem_adr", b_mem_adr, 32'd12);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk_b_idle_outputs("ra_async");
        step();
        chk("ra_no_done1", 32'(b_done1), 32'd0);
        chk("ra_no_done0", 32'(b_done0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("ra_first_gnt0", 32'(b_gnt0), 32'd1);
        chk("ra_first_gnt1", 32'(b_gnt1), 32'd0);
        chk("ra_mem_adr200", b_mem_adr, 32'd200);
        b_req0 = 1'b0; b_req1 = 1'b0;
        step();
        step();
        step();
        chk("ra_done0", 32'(b_done0), 32'd1);
        chk("ra_rd0", b_rd0, 32'h77);
        chk("ra_rd1_clear", b_rd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles (legal 1..15).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0/req1  input  1  access request from requester 0 (core) / 1 (loader/DMA).
REQ-007 we0/we1  input  1  write enable qualifying reqN.
REQ-008 adr0/adr1  input  AW  byte address qualifying reqN.
REQ-009 wd0/wd1  input  DW  write data qualifying reqN.
REQ-010 gnt0/gnt1  output  1  one-cycle pulse; request fields of that port were captured.
REQ-011 done0/done1  output  1  one-cycle pulse; transaction complete.
REQ-012 rd0/rd1  output  DW  read data, valid while doneN high; holds value until next doneN.
REQ-013 mem_we  output  1  write strobe to the shared unified memory.
REQ-014 mem_adr  output  AW  memory address.
REQ-015 mem_wd  output  DW  memory write data.
REQ-016 mem_rd  input  DW  memory read data, valid MEM_LAT cycles after mem_adr is presented.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; exactly one transaction is outstanding at a time.
REQ-018 IDLE: at an edge where req0|req1 is high, latch winner's we/adr/wd, go to ACCESS; otherwise stay in IDLE.
REQ-019 Arbitration round-robin: single requester wins; if both request, the port not granted last wins; the last-granted pointer resets to port 1, so port 0 wins first contention.
REQ-020 gntN is high for exactly the first ACCESS cycle of a port-N transaction; never both gnt high.
REQ-021 ACCESS: mem_adr/mem_wd drive latched values for all MEM_LAT cycles; mem_we high only in the first ACCESS cycle and only for writes.
REQ-022 A 4-bit counter loads MEM_LAT-1 on ACCESS entry, decrements each cycle; at 0 capture mem_rd into rdN and go to DONE.
REQ-023 DONE: doneN high for one cycle (writes included; rdN then updated with mem_rd, don't-care); next state IDLE.
REQ-024 Transaction length MEM_LAT+2 cycles from sampled req to IDLE; maximum throughput one transaction per MEM_LAT+2 cycles.
REQ-025 Requester holds reqN and fields stable until gntN; fields may change after gntN; a req held through doneN is a new request.
REQ-026 reqN dropped before grant: no transaction, no gnt, no done for it.
REQ-027 Request changes during ACCESS/DONE are ignored; arbitration is only evaluated in IDLE.
REQ-028 Outside ACCESS, mem_we is 0 and mem_adr/mem_wd hold last latched values.

Reset
REQ-029 reset low forces immediately: state IDLE, mem_we 0, gnt0/1 0, done0/1 0, counter 0, mem_adr 0, mem_wd 0, rd0/rd1 0, pointer = port 1.
REQ-030 Reset asserted mid-transaction aborts it: no doneN issued; a pending write whose mem_we already fired is not retracted.
REQ-031 First arbitration occurs at the first rising edge after reset deasserts.

Verification
REQ-032 MEM_LAT=1; req0 write adr 100 wd 7 -> gnt0 next cycle with mem_we=1, mem_adr=100, mem_wd=7; done0 two cycles later.
REQ-033 MEM_LAT=3; req1 read adr 96, memory holding 0x1234 -> gnt1, mem_we=0 for 3 cycles, done1 with rd1=0x1234, total 5 cycles.
REQ-034 Both req held continuously -> grants alternate 0,1,0,1; each port completes every 2*(MEM_LAT+2) cycles.
REQ-035 req1 pulsed for one cycle while port 0 in ACCESS -> ignored, no gnt1/done1.
REQ-036 reset low in ACCESS of a read -> all outputs 0 asynchronously, no done; after release, held req0 is granted first.
